// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-position shift controller.
// Holds the FSM state encoding, the shift-direction constants and the ALU
// datapath width. The ALU opcode decoder uses the same DIR_* constants, so
// both sides agree on what a direction bit means.
package shift_sequencer_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : shift_sequencer_pkg

// File: rtl/shift_sequencer_shifter.sv
// Single-position shifter stage.
// Purely combinational: presents both the one-bit-left and the one-bit-right
// (logical, zero fill) versions of its input. The controller chooses one of
// them each cycle.
// Ports:
//   din  in   WIDTH  value to shift by one position
//   shl  out  WIDTH  din << 1, LSB filled with 0
//   shr  out  WIDTH  din >> 1, MSB filled with 0
module shift_sequencer_shifter #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] shl,
  output logic [WIDTH-1:0] shr
);

  assign shl = {din[WIDTH-2:0], 1'b0};
  assign shr = {1'b0, din[WIDTH-1:1]};

endmodule : shift_sequencer_shifter

// File: rtl/shift_sequencer.sv
// Multi-position shift controller for the 16-bit ALU.
// Captures an operand, direction and amount on an accepted start, then steps
// the single-position shifter once per clock until the amount is used up and
// presents the result with a one-cycle done pulse.
// Ports:
//   clk     in   1      system clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request; only looked at in IDLE
//   dir     in   1      DIR_LEFT (<<) or DIR_RIGHT (>>, logical)
//   amount  in   CNT_W  number of positions to shift (0 allowed)
//   a       in   WIDTH  operand, captured together with start
//   busy    out  1      high in SHIFT and DONE
//   done    out  1      one-cycle pulse, result valid in the same cycle
//   result  out  WIDTH  registered result, held until the next one lands
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               dir_q,    dir_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]   acc_shl;
  logic [WIDTH-1:0]   acc_shr;
  logic [WIDTH-1:0]   acc_step;

  shift_sequencer_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .din (acc_q),
    .shl (acc_shl),
    .shr (acc_shr)
  );

  assign acc_step = (dir_q == DIR_RIGHT) ? acc_shr : acc_shl;

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = a;
          dir_d = dir;
          cnt_d = amount;
          if (amount == '0) begin
            // Nothing to shift: the operand itself is the answer.
            result_d = a;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          // Load result on the last step so it is already valid while
          // done is high; SHIFT is never entered with cnt==0, so the
          // counter cannot wrap.
          result_d = acc_step;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= DIR_LEFT;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule : shift_sequencer
